// File: rtl/bus_dispatch_ctrl_if.sv
// Host-bus and switch-FIFO signal bundle for bus_dispatch_ctrl.
// The slave modport is the dispatcher side; the master modport is the host/FIFO side.
interface bus_dispatch_ctrl_if #(
  parameter int NUM_SW_INST = 5,
  parameter int SW_ADDR_W   = 3,
  parameter int REG_ADDR_W  = 5,
  parameter int W_WIDTH     = 8,
  parameter int ID_WIDTH    = 8,
  parameter int FRAME_WIDTH = 32,
  parameter int CNT_WIDTH   = 8
);
  logic                            en_in;
  logic                            in_valid;
  logic                            in_ready;
  logic                            wr_rd_op;
  logic [ID_WIDTH-1:0]             op_id;
  logic [SW_ADDR_W+REG_ADDR_W-1:0] addr_in;
  logic [W_WIDTH-1:0]              wr_data_in;
  logic [NUM_SW_INST-1:0]          fifo_full;
  logic [FRAME_WIDTH-1:0]          frame_out;
  logic [NUM_SW_INST-1:0]          fifo_wr_en;
  logic                            addr_err;
  logic [CNT_WIDTH-1:0]            err_cnt;
  logic                            busy;

  modport slave (
    input  en_in, in_valid, wr_rd_op, op_id, addr_in, wr_data_in, fifo_full,
    output in_ready, frame_out, fifo_wr_en, addr_err, err_cnt, busy
  );

  modport master (
    output en_in, in_valid, wr_rd_op, op_id, addr_in, wr_data_in, fifo_full,
    input  in_ready, frame_out, fifo_wr_en, addr_err, err_cnt, busy
  );
endinterface

// File: rtl/bus_dispatch_ctrl.sv
// Packs host register-access transactions into frames and issues each to one
// switch-instance FIFO through a one-entry hold buffer with per-FIFO back-pressure.
module bus_dispatch_ctrl #(
  parameter int NUM_SW_INST = 5,
  parameter int SW_ADDR_W   = 3,
  parameter int REG_ADDR_W  = 5,
  parameter int W_WIDTH     = 8,
  parameter int ID_WIDTH    = 8,
  parameter int FRAME_WIDTH = 32,
  parameter int CNT_WIDTH   = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  bus_dispatch_ctrl_if.slave    bus
);

  localparam int ADDR_W = SW_ADDR_W + REG_ADDR_W;
  localparam logic [SW_ADDR_W:0] NUM_SEL = (SW_ADDR_W+1)'(NUM_SW_INST);

  typedef enum logic {S_EMPTY, S_HOLD} state_e;

  state_e                 state_q, state_d;
  logic [FRAME_WIDTH-1:0] hold_frame_q;
  logic [SW_ADDR_W-1:0]   hold_sel_q;
  logic [FRAME_WIDTH-1:0] frame_q, frame_d;
  logic [NUM_SW_INST-1:0] wr_en_q, wr_en_d;
  logic                   addr_err_q, addr_err_d;
  logic [CNT_WIDTH-1:0]   err_cnt_q, err_cnt_d;

  logic [SW_ADDR_W-1:0]   sw_sel;
  logic [REG_ADDR_W-1:0]  reg_addr;
  logic [FRAME_WIDTH-1:0] new_frame;
  logic                   addr_bad;
  logic                   hold_valid, issue_now, in_ready, accept, load;

  assign sw_sel    = bus.addr_in[ADDR_W-1 -: SW_ADDR_W];
  assign reg_addr  = bus.addr_in[REG_ADDR_W-1:0];
  assign addr_bad  = {1'b0, sw_sel} >= NUM_SEL;
  assign new_frame = FRAME_WIDTH'({reg_addr, bus.wr_rd_op, bus.wr_data_in, bus.op_id});

  // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_EMPTY;
    else        state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (load) state_d = S_HOLD;
      S_HOLD:  if (!load && issue_now) state_d = S_EMPTY;
      default: state_d = S_EMPTY;
    endcase
  end

  // A FIFO written last cycle is skipped so its full flag can catch up.
  always_comb begin
    hold_valid = (state_q == S_HOLD);
    issue_now  = hold_valid && !bus.fifo_full[hold_sel_q] && !wr_en_q[hold_sel_q];
    in_ready   = bus.en_in && (!hold_valid || issue_now);
    accept     = bus.in_valid && in_ready;
    load       = accept && !addr_bad;
  end

  always_comb begin
    wr_en_d    = '0;
    frame_d    = '0;
    if (issue_now) begin
      wr_en_d = NUM_SW_INST'(1) << hold_sel_q;
      frame_d = hold_frame_q;
    end
    addr_err_d = accept && addr_bad;
    err_cnt_d  = err_cnt_q;
    if (addr_err_d && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q    <= '0;
      frame_q    <= '0;
      addr_err_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      wr_en_q    <= wr_en_d;
      frame_q    <= frame_d;
      addr_err_q <= addr_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // NOTE: hold payload needs no reset; it is only observed while state_q is S_HOLD.
  always_ff @(posedge clk) begin
    if (load) begin
      hold_frame_q <= new_frame;
      hold_sel_q   <= sw_sel;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.frame_out  = frame_q;
  assign bus.fifo_wr_en = wr_en_q;
  assign bus.addr_err   = addr_err_q;
  assign bus.err_cnt    = err_cnt_q;
  assign bus.busy       = hold_valid;

endmodule

// File: tb/tb_bus_dispatch_ctrl.sv
// Self-checking bench for bus_dispatch_ctrl: directed vector table, reset and
// saturation sequences, then randomized traffic against a transaction-level model.
module tb_bus_dispatch_ctrl;

  localparam int NSW = 5, SWW = 3, RAW = 5, WW = 8, IDW = 8, FW = 32, CW = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bus_dispatch_ctrl_if #(.NUM_SW_INST(NSW), .SW_ADDR_W(SWW), .REG_ADDR_W(RAW),
    .W_WIDTH(WW), .ID_WIDTH(IDW), .FRAME_WIDTH(FW), .CNT_WIDTH(CW)) bus ();

  bus_dispatch_ctrl #(.NUM_SW_INST(NSW), .SW_ADDR_W(SWW), .REG_ADDR_W(RAW),
    .W_WIDTH(WW), .ID_WIDTH(IDW), .FRAME_WIDTH(FW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       en, vld, wr;
    logic [7:0] id, addr, data;
    logic [4:0] full;
    logic       rdy;
    logic [4:0] wen;
    logic [31:0] frame;
    logic       aerr;
    logic [7:0] ecnt;
    logic       busy;
  } vec_t;
  vec_t vecs[$];

  typedef struct {int sel; logic [31:0] frame;} hold_t;
  hold_t       m_hold[$];
  int          m_last;
  logic [4:0]  m_wen;
  logic [31:0] m_frame;
  logic        m_aerr;
  int          m_cnt;
  logic        m_acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic en, input logic vld, input logic wr, input logic [7:0] id,
                       input logic [7:0] addr, input logic [7:0] data, input logic [4:0] full);
    bus.en_in = en; bus.in_valid = vld; bus.wr_rd_op = wr; bus.op_id = id;
    bus.addr_in = addr; bus.wr_data_in = data; bus.fifo_full = full;
  endtask

  task automatic model_reset();
    m_hold.delete();
    m_last = -1; m_wen = '0; m_frame = '0; m_aerr = 1'b0; m_cnt = 0; m_acc = 1'b0;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 8'h0, 8'h0, 8'h0, 5'h0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  // One clock of the transaction-level model: the held frame goes out unless its
  // FIFO is full or was written on the previous cycle; frames are built arithmetically.
  task automatic cycle();
    logic can_issue, exp_rdy;
    int   sel;
    #1;
    can_issue = (m_hold.size() > 0) && !bus.fifo_full[m_hold[0].sel] && (m_hold[0].sel != m_last);
    exp_rdy   = bus.en_in && ((m_hold.size() == 0) || can_issue);
    check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    @(posedge clk);
    m_wen = '0; m_frame = '0; m_aerr = 1'b0; m_last = -1;
    if (can_issue) begin
      m_wen   = 5'(1 << m_hold[0].sel);
      m_frame = m_hold[0].frame;
      m_last  = m_hold[0].sel;
      void'(m_hold.pop_front());
    end
    m_acc = bus.in_valid && exp_rdy;
    if (m_acc) begin
      sel = int'(bus.addr_in) / 32;
      if (sel >= NSW) begin
        m_aerr = 1'b1;
        if (m_cnt < 255) m_cnt++;
      end else begin
        m_hold.push_back('{sel, 32'((int'(bus.addr_in) % 32) * 131072 + int'(bus.wr_rd_op) * 65536
                                   + int'(bus.wr_data_in) * 256 + int'(bus.op_id))});
      end
    end
    #1;
    check("fifo_wr_en", 32'(bus.fifo_wr_en), 32'(m_wen));
    check("frame_out",  bus.frame_out, m_frame);
    check("addr_err",   32'(bus.addr_err), 32'(m_aerr));
    check("err_cnt",    32'(bus.err_cnt), 32'(m_cnt));
    check("busy",       32'(bus.busy), 32'(m_hold.size() > 0));
  endtask

  function automatic vec_t idle(input logic rdy, input logic [4:0] wen, input logic [31:0] frame,
                                input logic aerr, input logic [7:0] ecnt, input logic busy);
    return '{1'b1, 1'b0, 1'b0, 8'h0, 8'h0, 8'h0, 5'h0, rdy, wen, frame, aerr, ecnt, busy};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // single write, then alternating switches 0/1
    vecs.push_back('{1'b1,1'b1,1'b1,8'h3C,8'h45,8'hA5,5'h00, 1'b1,5'h00,32'h0,1'b0,8'd0,1'b1});
    vecs.push_back(idle(1'b1,5'h04,32'h000BA53C,1'b0,8'd0,1'b0));
    vecs.push_back(idle(1'b1,5'h00,32'h0,1'b0,8'd0,1'b0));
    vecs.push_back('{1'b1,1'b1,1'b0,8'h01,8'h01,8'h10,5'h00, 1'b1,5'h00,32'h0,1'b0,8'd0,1'b1});
    vecs.push_back('{1'b1,1'b1,1'b0,8'h02,8'h22,8'h20,5'h00, 1'b1,5'h01,32'h00021001,1'b0,8'd0,1'b1});
    vecs.push_back('{1'b1,1'b1,1'b0,8'h03,8'h03,8'h30,5'h00, 1'b1,5'h02,32'h00042002,1'b0,8'd0,1'b1});
    vecs.push_back('{1'b1,1'b1,1'b0,8'h04,8'h24,8'h40,5'h00, 1'b1,5'h01,32'h00063003,1'b0,8'd0,1'b1});
    vecs.push_back(idle(1'b1,5'h02,32'h00084004,1'b0,8'd0,1'b0));
    vecs.push_back(idle(1'b1,5'h00,32'h0,1'b0,8'd0,1'b0));
    // back-to-back to switch 3: pulses spaced by one idle cycle
    vecs.push_back('{1'b1,1'b1,1'b1,8'h05,8'h61,8'h55,5'h00, 1'b1,5'h00,32'h0,1'b0,8'd0,1'b1});
    vecs.push_back('{1'b1,1'b1,1'b1,8'h06,8'h62,8'h66,5'h00, 1'b1,5'h08,32'h00035505,1'b0,8'd0,1'b1});
    vecs.push_back('{1'b1,1'b1,1'b0,8'h07,8'h63,8'h77,5'h00, 1'b0,5'h00,32'h0,1'b0,8'd0,1'b1});
    vecs.push_back('{1'b1,1'b1,1'b0,8'h07,8'h63,8'h77,5'h00, 1'b1,5'h08,32'h00056606,1'b0,8'd0,1'b1});
    vecs.push_back(idle(1'b0,5'h00,32'h0,1'b0,8'd0,1'b1));
    vecs.push_back(idle(1'b1,5'h08,32'h00067707,1'b0,8'd0,1'b0));
    vecs.push_back(idle(1'b1,5'h00,32'h0,1'b0,8'd0,1'b0));
    // back-pressure on switch 2 for 5 cycles
    vecs.push_back('{1'b1,1'b1,1'b0,8'h08,8'h4A,8'h88,5'h04, 1'b1,5'h00,32'h0,1'b0,8'd0,1'b1});
    for (int i = 0; i < 4; i++)
      vecs.push_back('{1'b1,1'b0,1'b0,8'h00,8'h00,8'h00,5'h04, 1'b0,5'h00,32'h0,1'b0,8'd0,1'b1});
    vecs.push_back(idle(1'b1,5'h04,32'h00148808,1'b0,8'd0,1'b0));
    vecs.push_back(idle(1'b1,5'h00,32'h0,1'b0,8'd0,1'b0));
    // bad addresses (sel 7, sel 5) and the last valid switch (sel 4)
    vecs.push_back('{1'b1,1'b1,1'b1,8'h09,8'hE0,8'h99,5'h00, 1'b1,5'h00,32'h0,1'b1,8'd1,1'b0});
    vecs.push_back(idle(1'b1,5'h00,32'h0,1'b0,8'd1,1'b0));
    vecs.push_back('{1'b1,1'b1,1'b0,8'h0C,8'hA3,8'hCC,5'h00, 1'b1,5'h00,32'h0,1'b1,8'd2,1'b0});
    vecs.push_back(idle(1'b1,5'h00,32'h0,1'b0,8'd2,1'b0));
    vecs.push_back('{1'b1,1'b1,1'b1,8'h0A,8'h80,8'hAA,5'h00, 1'b1,5'h00,32'h0,1'b0,8'd2,1'b1});
    vecs.push_back(idle(1'b1,5'h10,32'h0001AA0A,1'b0,8'd2,1'b0));
    vecs.push_back(idle(1'b1,5'h00,32'h0,1'b0,8'd2,1'b0));
    // disable while holding to a full switch 1
    vecs.push_back('{1'b1,1'b1,1'b1,8'h0B,8'h27,8'hBB,5'h02, 1'b1,5'h00,32'h0,1'b0,8'd2,1'b1});
    vecs.push_back('{1'b0,1'b0,1'b0,8'h00,8'h00,8'h00,5'h02, 1'b0,5'h00,32'h0,1'b0,8'd2,1'b1});
    vecs.push_back('{1'b0,1'b1,1'b0,8'h0D,8'h00,8'hDD,5'h02, 1'b0,5'h00,32'h0,1'b0,8'd2,1'b1});
    vecs.push_back('{1'b0,1'b1,1'b0,8'h0D,8'h00,8'hDD,5'h00, 1'b0,5'h02,32'h000FBB0B,1'b0,8'd2,1'b0});
    vecs.push_back('{1'b0,1'b1,1'b0,8'h0D,8'h00,8'hDD,5'h00, 1'b0,5'h00,32'h0,1'b0,8'd2,1'b0});
    vecs.push_back('{1'b0,1'b0,1'b0,8'h00,8'h00,8'h00,5'h00, 1'b0,5'h00,32'h0,1'b0,8'd2,1'b0});

    do_reset();
    check("reset.fifo_wr_en", 32'(bus.fifo_wr_en), 32'h0);
    check("reset.frame_out",  bus.frame_out, 32'h0);
    check("reset.addr_err",   32'(bus.addr_err), 32'h0);
    check("reset.err_cnt",    32'(bus.err_cnt), 32'h0);
    check("reset.busy",       32'(bus.busy), 32'h0);

    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].vld, vecs[i].wr, vecs[i].id, vecs[i].addr, vecs[i].data, vecs[i].full);
      #1;
      check($sformatf("vec%0d.in_ready", i), 32'(bus.in_ready), 32'(vecs[i].rdy));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d.fifo_wr_en", i), 32'(bus.fifo_wr_en), 32'(vecs[i].wen));
      check($sformatf("vec%0d.frame_out", i),  bus.frame_out, vecs[i].frame);
      check($sformatf("vec%0d.addr_err", i),   32'(bus.addr_err), 32'(vecs[i].aerr));
      check($sformatf("vec%0d.err_cnt", i),    32'(bus.err_cnt), 32'(vecs[i].ecnt));
      check($sformatf("vec%0d.busy", i),       32'(bus.busy), 32'(vecs[i].busy));
    end

    // reset while a frame for full switch 2 is held; it must not reappear
    do_reset();
    drive(1'b1, 1'b1, 1'b1, 8'h3C, 8'h45, 8'hA5, 5'h04);
    cycle();
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 5'h04);
    cycle();
    #2 rst_n = 1'b0;
    #1;
    check("midrst.fifo_wr_en", 32'(bus.fifo_wr_en), 32'h0);
    check("midrst.frame_out",  bus.frame_out, 32'h0);
    check("midrst.addr_err",   32'(bus.addr_err), 32'h0);
    check("midrst.err_cnt",    32'(bus.err_cnt), 32'h0);
    check("midrst.busy",       32'(bus.busy), 32'h0);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 5'h00);
    repeat (4) cycle();

    // 260 out-of-range accepts saturate the error counter
    for (int i = 0; i < 260; i++) begin
      drive(1'b1, 1'b1, 1'($urandom), 8'($urandom),
            {3'($urandom_range(5, 7)), 5'($urandom)}, 8'($urandom), 5'h00);
      cycle();
    end
    check("err_cnt.saturated", 32'(bus.err_cnt), 32'hFF);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 5'h00);
    cycle();

    // randomized traffic; the source holds a transaction until it is accepted
    do_reset();
    m_acc = 1'b1;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] full;
      for (int b = 0; b < NSW; b++) full[b] = ($urandom_range(0, 3) == 0);
      bus.fifo_full = full;
      bus.en_in = ($urandom_range(0, 9) != 0);
      if (m_acc || !bus.in_valid) begin
        bus.in_valid   = ($urandom_range(0, 3) != 0);
        bus.wr_rd_op   = 1'($urandom);
        bus.op_id      = 8'($urandom);
        bus.addr_in    = ($urandom_range(0, 7) == 0) ? {3'($urandom_range(5, 7)), 5'($urandom)}
                                                     : {3'($urandom_range(0, 4)), 5'($urandom)};
        bus.wr_data_in = 8'($urandom);
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_dispatch_ctrl.md
Name: bus_dispatch_ctrl

Overview:
Parametrised successor of the bus-to-switch frame builder. Accepts register-access transactions from the host bus over a valid/ready handshake. Packs each transaction into a frame and issues it to exactly one of NUM_SW_INST switch-instance FIFOs, honouring a per-FIFO full flag. Adds a one-entry hold buffer, per-destination back-pressure, out-of-range address detection with a saturating error counter, and a write-spacing rule that prevents FIFO overflow.

Parameters:
NUM_SW_INST, 5, number of switch FIFOs; must be <= 2**SW_ADDR_W
SW_ADDR_W, 3, switch-select field width (upper bits of addr_in)
REG_ADDR_W, 5, register-address field width (lower bits of addr_in)
W_WIDTH, 8, write-data width
ID_WIDTH, 8, operation-id width
FRAME_WIDTH, 32, frame width; must be >= REG_ADDR_W+1+W_WIDTH+ID_WIDTH
CNT_WIDTH, 8, error counter width

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
en_in  input  1  dispatcher enable
in_valid  input  1  transaction valid
in_ready  output  1  dispatcher can accept
wr_rd_op  input  1  1=write, 0=read
op_id  input  ID_WIDTH  operation id
addr_in  input  SW_ADDR_W+REG_ADDR_W  {switch sel, reg addr}
wr_data_in  input  W_WIDTH  write data
fifo_full  input  NUM_SW_INST  per-FIFO full flags
frame_out  output  FRAME_WIDTH  issued frame
fifo_wr_en  output  NUM_SW_INST  one-hot FIFO write strobe
addr_err  output  1  one-cycle pulse on out-of-range switch select
err_cnt  output  CNT_WIDTH  saturating count of address errors
busy  output  1  hold buffer occupied

Behaviour:
- Reset, asynchronous: frame_out=0, fifo_wr_en=0, addr_err=0, err_cnt=0, hold buffer empty, busy=0. A pending hold is discarded.
- Accept: occurs when in_valid && in_ready at a rising edge.
- in_ready = en_in && (!hold_valid || issue_now). This is combinational, so a new transaction can be accepted in the same cycle the hold entry issues.
- Frame format: {zero pad, reg_addr, wr_rd_op, wr_data_in, op_id}, with op_id in the LSBs. Reads carry wr_data_in unchanged.
- Address check at accept: if sw_sel >= NUM_SW_INST, the transaction is consumed but not loaded into the hold buffer.
  - addr_err is high for exactly the next cycle.
  - err_cnt increments by 1 and saturates at all-ones.
- Otherwise the frame and sw_sel load into the hold buffer and hold_valid is set.
- Issue: issue_now = hold_valid && !fifo_full[hold_sel] && !(fifo_wr_en[hold_sel] currently high).
  - Spacing rule: no issue to the same FIFO on consecutive cycles. This lets the FIFO's full flag update after each write.
  - On issue, the next cycle has fifo_wr_en = one-hot(hold_sel) for exactly one cycle and frame_out = the held frame. hold_valid clears unless a new accept reloads it.
- frame_out is 0 in every cycle fifo_wr_en is 0.
- Latency: accept at edge N; earliest fifo_wr_en is high in the cycle after edge N+1.
  - Sustained throughput is 1 frame/cycle to alternating FIFOs, 1 frame/2 cycles to a single FIFO.
- Back-pressure: while fifo_full[hold_sel]=1, the hold is kept, fifo_wr_en stays 0 and in_ready=0. Full flags of other FIFOs do not block.
- en_in=0: no new accepts; an occupied hold still drains. In-flight data is never dropped by deasserting en_in.
- in_valid without in_ready: no state change. The source must hold its inputs stable.
- busy = hold_valid.

Test Plan:
- Reset mid-hold: fifo_full=5'b00100, accept addr 0x45 (sel 2), assert rst_n=0 -> all outputs 0, busy=0; after release, no stale write is issued.
- Single write: en_in=1, addr_in=0x45, wr_rd_op=1, wr_data_in=0xA5, op_id=0x3C, fifos empty -> 2 cycles later fifo_wr_en=5'b00100 for 1 cycle, frame_out=0x000BA53C; frame_out=0 the next cycle.
- Back-to-back to switches 0,1,0,1 -> in_ready stays 1 and fifo_wr_en alternates 00001/00010 every cycle. Back-to-back to switch 3 -> 01000 pulses spaced by one idle cycle.
- Back-pressure: fifo_full[2]=1 for 5 cycles with a hold to sel 2 -> fifo_wr_en=0, in_ready=0, busy=1. Write issues 1 cycle after full drops.
- Bad address: addr_in=0xE0 (sel 7, NUM_SW_INST=5) -> addr_err pulses 1 cycle, err_cnt=1, no fifo_wr_en. 260 bad accepts -> err_cnt=0xFF, saturated.
- Disable while holding: en_in drops while fifo_full[1]=1 with a hold to sel 1 -> in_ready=0; the write issues after full clears, then the block idles.
